// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per clock over WIDTH cycles, with Busy/Done handshake to the decoder.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;

    state_t           state;
    logic [1:0]       op;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             sign1;
    logic             sign2;
    logic             div_zero;

    logic             in_signed;
    logic             in_sign1;
    logic             in_sign2;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   next_hi;
    logic [WIDTH-1:0]   next_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin1;
    logic [WIDTH-1:0]   fin2;

    // The most negative value maps onto itself, which reads correctly as unsigned 2^(WIDTH-1).
    always_comb begin
        in_signed = ~MCycleOp[0];
        in_sign1  = in_signed & Operand1[WIDTH-1];
        in_sign2  = in_signed & Operand2[WIDTH-1];
        abs1      = in_sign1 ? -Operand1 : Operand1;
        abs2      = in_sign2 ? -Operand2 : Operand2;
    end

    // hi:lo is the product accumulator for multiply and remainder:quotient for divide.
    always_comb begin
        sum     = '0;
        trial   = '0;
        next_hi = hi;
        next_lo = lo;
        if (!op[1]) begin
            sum     = {1'b0, hi} + (lo[0] ? {1'b0, a_reg} : '0);
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], lo[WIDTH-1:1]};
        end else begin
            trial = {hi, lo[WIDTH-1]};
            if (trial >= {1'b0, a_reg}) begin
                next_hi = trial[WIDTH-1:0] - a_reg;
                next_lo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = trial[WIDTH-1:0];
                next_lo = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign correction applied to the value produced by the final iteration.
    always_comb begin
        prod = {next_hi, next_lo};
        fin1 = '0;
        fin2 = '0;
        if (!op[1]) begin
            if (sign1 ^ sign2)
                prod = -prod;
            fin1 = prod[WIDTH-1:0];
            fin2 = prod[2*WIDTH-1:WIDTH];
        end else begin
            if (div_zero)
                fin1 = '1;
            else if (sign1 ^ sign2)
                fin1 = -next_lo;
            else
                fin1 = next_lo;
            fin2 = sign1 ? -next_hi : next_hi;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            op       <= '0;
            count    <= '0;
            a_reg    <= '0;
            hi       <= '0;
            lo       <= '0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            div_zero <= 1'b0;
            Result1  <= '0;
            Result2  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        op       <= MCycleOp;
                        count    <= '0;
                        hi       <= '0;
                        a_reg    <= MCycleOp[1] ? abs2 : abs1;
                        lo       <= MCycleOp[1] ? abs1 : abs2;
                        sign1    <= in_sign1;
                        sign2    <= in_sign2;
                        div_zero <= (Operand2 == '0);
                        Busy     <= 1'b1;
                        state    <= COMP;
                    end else begin
                        state <= IDLE;
                    end
                end
                COMP: begin
                    count <= count + 1'b1;
                    hi    <= next_hi;
                    lo    <= next_lo;
                    if (count == LAST) begin
                        Result1 <= fin1;
                        Result2 <= fin2;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed self-checking bench for mcycle_unit (WIDTH=32): latency, signed/unsigned
// mul/div, divide-by-zero, overflow, back-to-back issue and mid-operation reset.
module tb_mcycle_unit;

    localparam int W = 32;

    logic         CLK;
    logic         RESET;
    logic         Start;
    logic [1:0]   MCycleOp;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;
    logic         Busy;
    logic         Done;

    int checks = 0;
    int errors = 0;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the following rising edge is the issue edge.
    task automatic apply_stimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
    endtask

    // Counts rising edges from the issue edge (edge 1) until Done is seen at a falling edge.
    task automatic wait_done(input bit release_start, input bit scramble,
                             output int edges, output bit busy_ok);
        edges   = 0;
        busy_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK);
            edges++;
            if (edges == 1 && release_start) begin
                #1 Start = 1'b0;
            end
            @(negedge CLK);
            if (Done) break;
            if (!Busy) busy_ok = 1'b0;
            if (scramble && edges == 5) begin
                Operand1 = $urandom;
                Operand2 = $urandom;
                MCycleOp = 2'b01;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp1, input logic [W-1:0] exp2);
        int edges;
        bit busy_ok;
        apply_stimulus(op, a, b);
        wait_done(1'b1, 1'b0, edges, busy_ok);
        check_output({tag, ".edges"}, 64'(edges), 64'd33);
        check_output({tag, ".r1"}, 64'(Result1), 64'(exp1));
        check_output({tag, ".r2"}, 64'(Result2), 64'(exp2));
    endtask

    initial begin
        int edges;
        bit busy_ok;

        RESET    = 1'b1;
        Start    = 1'b0;
        MCycleOp = 2'b00;
        Operand1 = '0;
        Operand2 = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_output("reset.busy", 64'(Busy), 64'd0);
        check_output("reset.done", 64'(Done), 64'd0);
        check_output("reset.r1", 64'(Result1), 64'd0);
        check_output("reset.r2", 64'(Result2), 64'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // Unsigned multiply of all-ones, with busy and post-done checks.
        apply_stimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(1'b1, 1'b0, edges, busy_ok);
        check_output("umul_max.edges", 64'(edges), 64'd33);
        check_output("umul_max.busy_during", 64'(busy_ok), 64'd1);
        check_output("umul_max.busy_done", 64'(Busy), 64'd0);
        check_output("umul_max.r1", 64'(Result1), 64'h00000001);
        check_output("umul_max.r2", 64'(Result2), 64'hFFFFFFFE);
        @(negedge CLK);
        check_output("hold.done", 64'(Done), 64'd0);
        check_output("hold.r1", 64'(Result1), 64'h00000001);
        check_output("hold.r2", 64'(Result2), 64'hFFFFFFFE);

        run_op("smul_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF);
        @(negedge CLK);
        run_op("smul_negneg", 2'b00, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd25, 32'd0);
        @(negedge CLK);
        run_op("umul_carry", 2'b01, 32'h12345678, 32'h10, 32'h23456780, 32'h00000001);
        @(negedge CLK);
        run_op("sdiv_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        @(negedge CLK);
        run_op("sdiv_negdiv", 2'b10, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
        @(negedge CLK);
        run_op("udiv", 2'b11, 32'd100, 32'd7, 32'd14, 32'd2);
        @(negedge CLK);
        run_op("udiv_zero", 2'b11, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234);
        @(negedge CLK);
        run_op("sdiv_zero", 2'b10, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF7);
        @(negedge CLK);
        run_op("sdiv_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        @(negedge CLK);

        // Start held high and inputs scrambled mid-op, then back-to-back issue from DONE.
        apply_stimulus(2'b11, 32'd100, 32'd7);
        wait_done(1'b0, 1'b1, edges, busy_ok);
        check_output("held.edges", 64'(edges), 64'd33);
        check_output("held.busy_during", 64'(busy_ok), 64'd1);
        check_output("held.r1", 64'(Result1), 64'd14);
        check_output("held.r2", 64'(Result2), 64'd2);
        apply_stimulus(2'b00, 32'hFFFFFFFD, 32'd7);
        wait_done(1'b1, 1'b0, edges, busy_ok);
        check_output("b2b.edges", 64'(edges), 64'd33);
        check_output("b2b.r1", 64'(Result1), 64'hFFFFFFEB);
        check_output("b2b.r2", 64'(Result2), 64'hFFFFFFFF);
        @(negedge CLK);
        check_output("b2b.done_pulse", 64'(Done), 64'd0);

        // Reset during computation discards partial work.
        apply_stimulus(2'b01, 32'd1000, 32'd1000);
        @(posedge CLK);
        #1 Start = 1'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_output("midrst.busy", 64'(Busy), 64'd0);
        check_output("midrst.done", 64'(Done), 64'd0);
        check_output("midrst.r1", 64'(Result1), 64'd0);
        check_output("midrst.r2", 64'(Result2), 64'd0);
        RESET = 1'b0;
        @(negedge CLK);
        run_op("after_rst", 2'b11, 32'd100, 32'd7, 32'd14, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
